// File: rtl/cam_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cam_cfg_pkg
// Shared definitions for the camera register-configuration sequencer:
//   - cfg_state_t   : sequencer FSM state encoding
//   - END_DATA      : data byte of the end-of-table marker
//   - DELAY_DATA    : data byte of the delay marker
//   - reg_all_ones(): all-ones register field for 8-bit or 16-bit addressing
// -----------------------------------------------------------------------------
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_ACK = 4'd4,
    ST_DELAY    = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FINISH   = 4'd7,
    ST_ABORT    = 4'd8
  } cfg_state_t;

  localparam logic [7:0] END_DATA   = 8'hFF;
  localparam logic [7:0] DELAY_DATA = 8'hF0;

  // Marker register field: 0xFF for 8-bit addressing, 0xFFFF for 16-bit.
  // Returned zero-extended to 16 bits; callers truncate to their own width.
  function automatic logic [15:0] reg_all_ones(input logic addr16);
    logic [15:0] ones_s;
    if (addr16) begin
      ones_s = 16'hFFFF;
    end else begin
      ones_s = 16'h00FF;
    end
    return ones_s;
  endfunction

endpackage

// File: rtl/cam_cfg_delay_timer.sv
// -----------------------------------------------------------------------------
// cam_cfg_delay_timer
// Loadable down-counter used to time in-ROM delay markers.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset (counter cleared)
//   load     : load the counter with load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; saturates at zero
//   zero     : counter currently holds zero
// -----------------------------------------------------------------------------
module cam_cfg_delay_timer #(
  parameter  int DELAY_CYCLES = 500000,
  localparam int CW           = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_r;

  // Down-counter: load wins, decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CW{1'b0}})) begin
      count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CW{1'b0}});

endmodule

// File: rtl/cam_config_sequencer.sv
// -----------------------------------------------------------------------------
// cam_config_sequencer
// Walks the camera configuration ROM from address 0, issuing one SCCB register
// write per entry, honouring delay and end markers, and reporting completion.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle pulse, begins a pass (ignored while busy)
//   rom_addr          : registered ROM address
//   rom_data          : ROM word {reg_addr, reg_data[7:0]}, sync ROM
//   sccb_start        : one-cycle write request to the SCCB master
//   sccb_ready        : SCCB master idle
//   sccb_nack         : write failed, valid when ready returns
//   sccb_reg_addr     : register address of the current write
//   sccb_data         : register data of the current write
//   busy, done, error : pass in progress / last pass ok / last pass NACKed
// -----------------------------------------------------------------------------
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter  int I2C_ADDR_16  = 0,
  parameter  int DELAY_CYCLES = 500000,
  parameter  int LAST_ADDR    = 1023,
  localparam int RAW          = 8 + 8 * I2C_ADDR_16,
  localparam int RDW          = 16 + 8 * I2C_ADDR_16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [9:0]     rom_addr,
  input  logic [RDW-1:0] rom_data,
  output logic           sccb_start,
  input  logic           sccb_ready,
  input  logic           sccb_nack,
  output logic [RAW-1:0] sccb_reg_addr,
  output logic [7:0]     sccb_data,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int             DW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DW-1:0]  DLOAD    = DW'(DELAY_CYCLES - 1);
  localparam logic [9:0]     LAST     = 10'(LAST_ADDR);
  localparam logic [RAW-1:0] REG_ONES = RAW'(reg_all_ones(I2C_ADDR_16 != 0));

  cfg_state_t     state_r;
  logic [9:0]     rom_addr_r;
  logic           sccb_start_r;
  logic [RAW-1:0] reg_addr_r;
  logic [7:0]     data_r;
  logic           busy_r;
  logic           done_r;
  logic           error_r;
  // High during the first WAIT_ACK cycle, while the master is still dropping ready.
  logic           ack_skip_r;

  logic [RAW-1:0] ent_reg_s;
  logic [7:0]     ent_data_s;
  logic           is_end_s;
  logic           is_delay_s;
  logic           timer_load_s;
  logic           timer_dec_s;
  logic           timer_zero_s;

  assign ent_reg_s  = rom_data[RDW-1:8];
  assign ent_data_s = rom_data[7:0];
  assign is_end_s   = (ent_reg_s == REG_ONES) && (ent_data_s == END_DATA);
  assign is_delay_s = (ent_reg_s == REG_ONES) && (ent_data_s == DELAY_DATA);

  // Counter is loaded with DELAY_CYCLES-1 so DELAY lasts exactly DELAY_CYCLES cycles.
  assign timer_load_s = (state_r == ST_DECODE) && is_delay_s;
  assign timer_dec_s  = (state_r == ST_DELAY);

  cam_cfg_delay_timer #(
    .DELAY_CYCLES (DELAY_CYCLES)
  ) u_delay_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (DLOAD),
    .dec      (timer_dec_s),
    .zero     (timer_zero_s)
  );

  // Sequencer FSM with address counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rom_addr_r   <= 10'd0;
      sccb_start_r <= 1'b0;
      reg_addr_r   <= {RAW{1'b0}};
      data_r       <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      ack_skip_r   <= 1'b0;
    end else begin
      sccb_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b1;
            rom_addr_r <= 10'd0;
            state_r    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_end_s) begin
            state_r <= ST_FINISH;
          end else if (is_delay_s) begin
            state_r <= ST_DELAY;
          end else begin
            reg_addr_r <= ent_reg_s;
            data_r     <= ent_data_s;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sccb_ready) begin
            sccb_start_r <= 1'b1;
            ack_skip_r   <= 1'b1;
            state_r      <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_skip_r) begin
            ack_skip_r <= 1'b0;
          end else if (sccb_ready) begin
            state_r <= sccb_nack ? ST_ABORT : ST_NEXT;
          end
        end
        ST_DELAY: begin
          if (timer_zero_s) begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          // No wrap: reaching LAST_ADDR ends the pass even without an end marker.
          if (rom_addr_r == LAST) begin
            state_r <= ST_FINISH;
          end else begin
            rom_addr_r <= rom_addr_r + 10'd1;
            state_r    <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        ST_ABORT: begin
          // rom_addr stays on the failing entry for diagnosis.
          busy_r  <= 1'b0;
          error_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr      = rom_addr_r;
  assign sccb_start    = sccb_start_r;
  assign sccb_reg_addr = reg_addr_r;
  assign sccb_data     = data_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_cam_config_sequencer.sv
`timescale 1ns/1ps
// Testbench for cam_config_sequencer. Two instances: A (8-bit register
// addresses, 100-cycle delay, last address 3) and B (16-bit register
// addresses, 20-cycle delay, last address 7). One is active at a time (sel).
// A scoreboard queue holds expected {reg16, data8} writes; a monitor process
// pops and compares on every sccb_start pulse.
module tb_cam_config_sequencer;

  localparam int A_DELAY = 100;
  localparam int A_LAST  = 3;
  localparam int B_DELAY = 20;
  localparam int B_LAST  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        sccb_ready, sccb_nack;
  logic [9:0]  rom_addr_a, rom_addr_b;
  logic [15:0] rom_data_a;
  logic [23:0] rom_data_b;
  logic        sccb_start_a, sccb_start_b;
  logic [7:0]  reg_a;
  logic [15:0] reg_b;
  logic [7:0]  data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b, error_a, error_b;

  always #5 clk = ~clk;

  cam_config_sequencer #(.I2C_ADDR_16(0), .DELAY_CYCLES(A_DELAY), .LAST_ADDR(A_LAST)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .sccb_start(sccb_start_a), .sccb_ready(sccb_ready), .sccb_nack(sccb_nack),
    .sccb_reg_addr(reg_a), .sccb_data(data_a), .busy(busy_a), .done(done_a), .error(error_a));

  cam_config_sequencer #(.I2C_ADDR_16(1), .DELAY_CYCLES(B_DELAY), .LAST_ADDR(B_LAST)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sccb_start(sccb_start_b), .sccb_ready(sccb_ready), .sccb_nack(sccb_nack),
    .sccb_reg_addr(reg_b), .sccb_data(data_b), .busy(busy_b), .done(done_b), .error(error_b));

  // Synchronous ROM (one cycle read latency); A uses the low 16 bits.
  logic [23:0] rom [0:7];
  always @(posedge clk) begin
    rom_data_a <= rom[rom_addr_a[2:0]][15:0];
    rom_data_b <= rom[rom_addr_b[2:0]];
  end

  // Observation mux for the active instance.
  logic        sel;
  logic        obs_start, obs_busy, obs_done, obs_error;
  logic [15:0] obs_reg;
  logic [7:0]  obs_data;
  logic [9:0]  obs_addr;
  always_comb begin
    if (sel) begin
      obs_start = sccb_start_b; obs_reg = reg_b; obs_data = data_b;
      obs_busy = busy_b; obs_done = done_b; obs_error = error_b; obs_addr = rom_addr_b;
    end else begin
      obs_start = sccb_start_a; obs_reg = {8'h00, reg_a}; obs_data = data_a;
      obs_busy = busy_a; obs_done = done_a; obs_error = error_a; obs_addr = rom_addr_a;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s event missing", name);
  endtask

  // ---------------- SCCB master model ----------------
  int lat_cfg = 20;   // cycles ready stays low after each write request
  int nack_at = -1;   // index (within the pass) of the write that NACKs
  int wr_seen = 0;
  int stall   = 0;    // idle cycles to hold ready low before a pass
  int cnt     = 0;
  int ret_cyc[$];     // cycle in which ready came back after each write

  initial begin
    sccb_ready = 1'b1;
    sccb_nack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        sccb_ready = 1'b1; sccb_nack = 1'b0; cnt = 0; stall = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sccb_ready = 1'b1;
          sccb_nack  = ((wr_seen - 1) == nack_at);
          ret_cyc.push_back(cyc);
        end
      end else if (obs_start) begin
        sccb_ready = 1'b0; sccb_nack = 1'b0; cnt = lat_cfg; wr_seen++;
      end else if (stall > 0) begin
        stall--;
        sccb_ready = (stall == 0);
      end
    end
  end

  // ---------------- Scoreboard monitor ----------------
  logic [23:0] exp_q[$];
  int          start_cyc[$];
  int          max_addr = 0;
  int          done_rises = 0;
  logic        prev_done = 1'b0;

  initial begin
    logic        rdy_e;
    logic [23:0] e;
    forever begin
      @(posedge clk);
      rdy_e = sccb_ready;
      #1;
      if (obs_done && !prev_done) done_rises++;
      prev_done = obs_done;
      if (int'(obs_addr) > max_addr) max_addr = int'(obs_addr);
      if (obs_start) begin
        start_cyc.push_back(cyc);
        check("start_with_ready", int'(rdy_e), 1);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got reg=%h data=%h, no write expected", obs_reg, obs_data);
        end else begin
          e = exp_q.pop_front();
          if ({obs_reg, obs_data} !== e) begin
            failures++;
            $display("FAIL write got reg=%h data=%h exp reg=%h data=%h", obs_reg, obs_data, e[23:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- Reference model (from entry rules) ----------------
  task automatic model_pass(output bit e_err, output int e_addr);
    int          last;
    logic [15:0] ones;
    int          w;
    bit          stop;
    last   = sel ? B_LAST : A_LAST;
    ones   = sel ? 16'hFFFF : 16'h00FF;
    w      = 0;
    stop   = 1'b0;
    e_err  = 1'b0;
    e_addr = last;
    for (int i = 0; i <= last && !stop; i++) begin
      logic [15:0] r;
      logic [7:0]  d;
      r = sel ? rom[i][23:8] : {8'h00, rom[i][15:8]};
      d = rom[i][7:0];
      if (r == ones && d == 8'hFF) begin
        e_addr = i; stop = 1'b1;
      end else if (!(r == ones && d == 8'hF0)) begin
        exp_q.push_back({r, d});
        if (w == nack_at) begin
          e_err = 1'b1; e_addr = i; stop = 1'b1;
        end
        w++;
      end
    end
  endtask

  task automatic rand_rom();
    logic [15:0] ones;
    ones = sel ? 16'hFFFF : 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      int          k;
      logic [15:0] r;
      logic [7:0]  d;
      k = $urandom_range(0, 11);
      r = sel ? 16'($urandom) : {8'h00, 8'($urandom)};
      d = 8'($urandom);
      case (k)
        0: begin r = ones; d = 8'hFF; end
        1: begin r = ones; d = 8'hF0; end
        2: r = ones;
        3: begin r = 16'h00FF; d = 8'hFF; end
        default: ;
      endcase
      rom[i] = {r, d};
    end
  endtask

  // ---------------- Pass driver ----------------
  int sb_base, rb_base;

  task automatic run_pass(input string name, input bit e_err, input int e_addr, output int s_cyc);
    int t;
    wr_seen = 0;
    max_addr = 0;
    sb_base = start_cyc.size();
    rb_base = ret_cyc.size();
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    t = 0;
    while (!(obs_done || obs_error) && t < 6000) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_timeout"}, int'(t < 6000), 1);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_done"}, int'(obs_done), int'(!e_err));
    check({name, "_error"}, int'(obs_error), int'(e_err));
    check({name, "_busy"}, int'(obs_busy), 0);
    check({name, "_rom_addr"}, int'(obs_addr), e_addr);
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Test sequence ----------------
  initial begin
    int  s, t, rb0, dr0;
    bit  e_err;
    int  e_addr;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", int'({rom_addr_a, sccb_start_a, reg_a, data_a, busy_a, done_a, error_a}), 0);
    check("reset_b", int'({rom_addr_b, sccb_start_b, reg_b, data_b, busy_b, done_b, error_b}), 0);
    rst = 1'b0;

    // Nominal pass, 8-bit addressing.
    rom[0] = 24'h001280; rom[1] = 24'h001101; rom[2] = 24'h00FFFF; rom[3] = 24'h001122;
    lat_cfg = 20; nack_at = -1;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101);
    run_pass("nominal", 1'b0, 2, s);
    if (start_cyc.size() > sb_base) check("start_latency", start_cyc[sb_base] - s, 4);
    else fail_now("start_latency");

    // Delay marker, with a start issued mid-delay that must be ignored.
    rom[0] = 24'h001280; rom[1] = 24'h00FFF0; rom[2] = 24'h001101; rom[3] = 24'h00FFFF;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101);
    rb0 = ret_cyc.size();
    dr0 = done_rises;
    fork
      run_pass("delay", 1'b0, 3, s);
      begin
        t = 0;
        while (ret_cyc.size() <= rb0 && t < 500) begin @(posedge clk); #1; t++; end
        repeat (40) @(posedge clk);
        #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
      end
    join
    // Ready seen -> NEXT,FETCH,DECODE, DELAY x100, NEXT,FETCH,DECODE,ISSUE, pulse.
    if (start_cyc.size() > sb_base + 1 && ret_cyc.size() > rb_base)
      check("delay_gap", start_cyc[sb_base + 1] - ret_cyc[rb_base], A_DELAY + 8);
    else fail_now("delay_gap");
    check("pass_count_busy_start", done_rises - dr0, 1);

    // NACK on the second write, then restart from address 0.
    rom[0] = 24'h001280; rom[1] = 24'h001101; rom[2] = 24'h001302; rom[3] = 24'h00FFFF;
    nack_at = 1;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101);
    run_pass("nack", 1'b1, 1, s);
    nack_at = -1;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101); exp_q.push_back(24'h001302);
    run_pass("restart", 1'b0, 3, s);

    // No end marker: implicit end at the last address.
    rom[0] = 24'h000A01; rom[1] = 24'h000B02; rom[2] = 24'h000C03; rom[3] = 24'h000D04;
    lat_cfg = 5;
    exp_q.push_back(24'h000A01); exp_q.push_back(24'h000B02);
    exp_q.push_back(24'h000C03); exp_q.push_back(24'h000D04);
    run_pass("no_end", 1'b0, 3, s);
    check("no_end_max_addr", max_addr, 3);

    // Reset during WAIT_ACK.
    rom[0] = 24'h001280; rom[1] = 24'h001101; rom[2] = 24'h00FFFF;
    lat_cfg = 20;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101);
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    t = 0;
    while (!sccb_start_a && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) fail_now("rst_wait_start");
    #3 rst = 1'b1;
    #1;
    check("rst_mid", int'({rom_addr_a, sccb_start_a, reg_a, data_a, busy_a, done_a, error_a}), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(24'h001280); exp_q.push_back(24'h001101);
    run_pass("after_rst", 1'b0, 2, s);

    // Randomized passes on instance A, one with ready held low at start.
    for (int n = 0; n < 6; n++) begin
      rand_rom();
      lat_cfg = $urandom_range(1, 12);
      nack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (n == 0) stall = 15;
      model_pass(e_err, e_addr);
      run_pass("rand_a", e_err, e_addr, s);
    end

    // 16-bit addressing.
    sel = 1'b1;
    nack_at = -1; lat_cfg = 20;
    rom[0] = 24'h300812; rom[1] = 24'hFFFFFF;
    exp_q.push_back(24'h300812);
    run_pass("addr16", 1'b0, 1, s);

    for (int n = 0; n < 6; n++) begin
      rand_rom();
      lat_cfg = $urandom_range(1, 12);
      nack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      model_pass(e_err, e_addr);
      run_pass("rand_b", e_err, e_addr, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
